// File: rtl/rssi_pkg.sv
// rssi_pkg: shared types and elaboration helpers for the RSSI power sequencer.
// Optional feature macro used elsewhere in this slice: RSSI_PEAK_HOLD_EN.
package rssi_pkg;

    // Sequencer states: wait, square I, square Q, publish the window sum.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ST_I  = 2'd1,
        ST_Q  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Largest LOG2_WIN for which N * 2 * (-2^(IW-1))^2 still fits below the
    // MAC sign bit, so the window sum can be treated as unsigned.
    function automatic int max_log2_win(input int iw, input int pw);
        return pw - 2 * iw - 1;
    endfunction

endpackage

// File: rtl/rssi_peak_hold.sv
// rssi_peak_hold: tracks the largest window power since reset or clear.
// Instantiated by rssi_pow_ctrl only when RSSI_PEAK_HOLD_EN is defined.
module rssi_peak_hold #(
    parameter int PW = 37
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pwr_valid,
    input  logic          peak_clr,
    input  logic [PW-1:0] pwr_in,
    output logic [PW-1:0] peak_out
);

    logic [PW-1:0] peak_q;
    logic [PW-1:0] peak_d;

    // A new result wins over a clear so a cleared peak restarts from it.
    always_comb begin
        peak_d = peak_q;
        if (pwr_valid) begin
            if (peak_clr || (pwr_in > peak_q)) begin
                peak_d = pwr_in;
            end
        end else if (peak_clr) begin
            peak_d = '0;
        end
    end

    // Peak register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_out = peak_q;

endmodule

// File: rtl/rssi_pow_ctrl.sv
// rssi_pow_ctrl: drives an external MAC slice (P <= A*B+C or P <= P+A*B) to
// compute the windowed mean power sum(I^2+Q^2) >> LOG2_WIN of an I/Q stream.
// Optional: define RSSI_PEAK_HOLD_EN to add PEAK_CLR / PEAK_OUT peak tracking.
module rssi_pow_ctrl
    import rssi_pkg::*;
#(
    parameter int IW       = 12,
    parameter int PW       = 37,
    parameter int LOG2_WIN = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EN,
    input  logic                 S_VALID,
    output logic                 S_READY,
    input  logic signed [IW-1:0] S_I,
    input  logic signed [IW-1:0] S_Q,
    output logic                 MAC_SEL,
    output logic signed [IW-1:0] MAC_A,
    output logic signed [IW-1:0] MAC_B,
    output logic signed [IW-1:0] MAC_C,
    input  logic        [PW-1:0] MAC_P,
    output logic        [PW-1:0] PWR_OUT,
    output logic                 PWR_VALID
`ifdef RSSI_PEAK_HOLD_EN
    ,
    input  logic                 PEAK_CLR,
    output logic        [PW-1:0] PEAK_OUT
`endif
);

    localparam int MAX_LOG2_WIN = max_log2_win(IW, PW);

    // Reject window sizes that could overflow into the MAC sign bit.
    if (LOG2_WIN < 1 || LOG2_WIN > MAX_LOG2_WIN) begin : g_bad_cfg
        $error("rssi_pow_ctrl: LOG2_WIN out of range for IW/PW");
    end

    state_e                state_q,     state_d;
    logic                  first_q,     first_d;
    logic [LOG2_WIN-1:0]   count_q,     count_d;
    logic signed [IW-1:0]  q_samp_q,    q_samp_d;
    logic [PW-1:0]         pwr_out_q,   pwr_out_d;
    logic                  pwr_valid_q, pwr_valid_d;

    logic                  s_ready;
    logic                  mac_sel;
    logic signed [IW-1:0]  mac_op;

    // Next-state and MAC operand decode. When no sample is squared, the
    // operands are forced to zero so the accumulate mode adds nothing and
    // the load mode clears P; first selects load on the window's first op.
    always_comb begin
        state_d     = state_q;
        first_d     = first_q;
        count_d     = count_q;
        q_samp_d    = q_samp_q;
        pwr_out_d   = pwr_out_q;
        pwr_valid_d = 1'b0;
        s_ready     = 1'b0;
        mac_sel     = 1'b0;
        mac_op      = '0;
        case (state_q)
            IDLE: begin
                count_d = '0;
                first_d = 1'b1;
                if (EN) begin
                    state_d = ST_I;
                end
            end
            ST_I: begin
                s_ready = 1'b1;
                mac_sel = ~first_q;
                if (S_VALID) begin
                    mac_op   = S_I;
                    q_samp_d = S_Q;
                    state_d  = ST_Q;
                end else if (!EN) begin
                    state_d = IDLE;
                end
            end
            ST_Q: begin
                mac_sel = 1'b1;
                mac_op  = q_samp_q;
                first_d = 1'b0;
                if (count_q == '1) begin
                    count_d = '0;
                    state_d = DRAIN;
                end else begin
                    count_d = count_q + 1'b1;
                    state_d = EN ? ST_I : IDLE;
                end
            end
            DRAIN: begin
                mac_sel     = 1'b1;
                pwr_out_d   = MAC_P >> LOG2_WIN;
                pwr_valid_d = 1'b1;
                first_d     = 1'b1;
                state_d     = EN ? ST_I : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial window.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            first_q     <= 1'b1;
            count_q     <= '0;
            q_samp_q    <= '0;
            pwr_out_q   <= '0;
            pwr_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            count_q     <= count_d;
            q_samp_q    <= q_samp_d;
            pwr_out_q   <= pwr_out_d;
            pwr_valid_q <= pwr_valid_d;
        end
    end

    assign S_READY   = s_ready;
    assign MAC_SEL   = mac_sel;
    assign MAC_A     = mac_op;
    assign MAC_B     = mac_op;
    assign MAC_C     = '0;
    assign PWR_OUT   = pwr_out_q;
    assign PWR_VALID = pwr_valid_q;

`ifdef RSSI_PEAK_HOLD_EN
    rssi_peak_hold #(
        .PW (PW)
    ) u_peak_hold (
        .clk       (CLK),
        .rst       (RST),
        .pwr_valid (pwr_valid_q),
        .peak_clr  (PEAK_CLR),
        .pwr_in    (pwr_out_q),
        .peak_out  (PEAK_OUT)
    );
`endif

endmodule

// File: tb/tb_rssi_pow_ctrl.sv
// tb_rssi_pow_ctrl: directed bench pairing rssi_pow_ctrl with a behavioural
// MAC slice. Instance a uses LOG2_WIN=2, instance b uses LOG2_WIN=4.
// Define RSSI_PEAK_HOLD_EN to also exercise the peak-hold outputs.
module tb_rssi_pow_ctrl;

    localparam int IW = 12;
    localparam int PW = 37;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en_a, en_b;
    logic                 s_valid;
    logic signed [IW-1:0] s_i, s_q;

    logic                 s_ready_a, s_ready_b;
    logic                 mac_sel_a, mac_sel_b;
    logic signed [IW-1:0] mac_a_a, mac_b_a, mac_c_a;
    logic signed [IW-1:0] mac_a_b, mac_b_b, mac_c_b;
    logic        [PW-1:0] mac_p_a = '0;
    logic        [PW-1:0] mac_p_b = '0;
    logic        [PW-1:0] pwr_out_a, pwr_out_b;
    logic                 pwr_valid_a, pwr_valid_b;
`ifdef RSSI_PEAK_HOLD_EN
    logic                 peak_clr;
    logic        [PW-1:0] peak_out_a, peak_out_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rssi_pow_ctrl #(.IW(IW), .PW(PW), .LOG2_WIN(2)) dut_a (
        .CLK(clk), .RST(rst), .EN(en_a), .S_VALID(s_valid), .S_READY(s_ready_a),
        .S_I(s_i), .S_Q(s_q), .MAC_SEL(mac_sel_a), .MAC_A(mac_a_a), .MAC_B(mac_b_a),
        .MAC_C(mac_c_a), .MAC_P(mac_p_a), .PWR_OUT(pwr_out_a), .PWR_VALID(pwr_valid_a)
`ifdef RSSI_PEAK_HOLD_EN
        , .PEAK_CLR(peak_clr), .PEAK_OUT(peak_out_a)
`endif
    );

    rssi_pow_ctrl #(.IW(IW), .PW(PW), .LOG2_WIN(4)) dut_b (
        .CLK(clk), .RST(rst), .EN(en_b), .S_VALID(s_valid), .S_READY(s_ready_b),
        .S_I(s_i), .S_Q(s_q), .MAC_SEL(mac_sel_b), .MAC_A(mac_a_b), .MAC_B(mac_b_b),
        .MAC_C(mac_c_b), .MAC_P(mac_p_b), .PWR_OUT(pwr_out_b), .PWR_VALID(pwr_valid_b)
`ifdef RSSI_PEAK_HOLD_EN
        , .PEAK_CLR(peak_clr), .PEAK_OUT(peak_out_b)
`endif
    );

    function automatic logic [PW-1:0] sext_prod(input logic signed [IW-1:0] a,
                                                input logic signed [IW-1:0] b);
        logic signed [2*IW-1:0] p;
        p = a * b;
        return {{(PW-2*IW){p[2*IW-1]}}, p};
    endfunction

    function automatic logic [PW-1:0] sext_c(input logic signed [IW-1:0] c);
        return {{(PW-IW){c[IW-1]}}, c};
    endfunction

    // Behavioural MAC slices: registered P, load or accumulate.
    always @(posedge clk) begin
        if (mac_sel_a) mac_p_a <= mac_p_a + sext_prod(mac_a_a, mac_b_a);
        else           mac_p_a <= sext_prod(mac_a_a, mac_b_a) + sext_c(mac_c_a);
        if (mac_sel_b) mac_p_b <= mac_p_b + sext_prod(mac_a_b, mac_b_b);
        else           mac_p_b <= sext_prod(mac_a_b, mac_b_b) + sext_c(mac_c_b);
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Starts a window on dut_a from IDLE, feeds S_VALID on every m-th cycle and
    // checks accept pattern, op selection, stall operands and result timing.
    task automatic run_window(input string tag, input int m, input logic [63:0] exp_pwr,
                              input int exp_cyc, input logic [63:0] exp_mask);
        int          c;
        bit          done;
        int          accepts;
        logic [63:0] amask;
        c = 0; done = 0; accepts = 0; amask = '0;
        en_a = 1'b1; s_valid = 1'b0;
        step();
        while (!done && c < 200) begin
            s_valid = ((c % m) == 0);
            #1;
            if (pwr_valid_a) begin
                done = 1;
                chk({tag, "_cycle"}, c, exp_cyc);
                chk({tag, "_pwr"}, pwr_out_a, exp_pwr);
                chk({tag, "_mask"}, amask, exp_mask);
            end else begin
                if (s_ready_a && s_valid) begin
                    chk({tag, "_sel_acc"}, mac_sel_a, (accepts > 0));
                    chk({tag, "_a_acc"}, mac_a_a, s_i);
                    if (c < 64) amask[c] = 1'b1;
                    accepts++;
                end else if (s_ready_a && accepts > 0) begin
                    chk({tag, "_sel_stall"}, mac_sel_a, 1);
                    chk({tag, "_ab_stall"}, {mac_a_a, mac_b_a}, 0);
                end
                step();
                c++;
            end
        end
        chk({tag, "_done"}, done, 1);
    endtask

    task automatic finish_window(input string tag, input bit clr);
        en_a = 1'b0; s_valid = 1'b0;
`ifdef RSSI_PEAK_HOLD_EN
        peak_clr = clr;
`endif
        step();
`ifdef RSSI_PEAK_HOLD_EN
        peak_clr = 1'b0;
`endif
        chk({tag, "_pulse"}, pwr_valid_a, (clr & 1'b0));
    endtask

    initial begin
        int          c;
        bit          done;
        logic [PW-1:0] prev_p;

        rst = 1'b1; en_a = 1'b0; en_b = 1'b0; s_valid = 1'b0; s_i = '0; s_q = '0;
`ifdef RSSI_PEAK_HOLD_EN
        peak_clr = 1'b0;
`endif
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_ready", s_ready_a, 0);
        chk("rst_sel", mac_sel_a, 0);
        chk("rst_abc", {mac_a_a, mac_b_a, mac_c_a}, 0);
        chk("rst_pwr", pwr_out_a, 0);
        chk("rst_valid", pwr_valid_a, 0);
        step();

        // Test 1: full rate, I=3 Q=4, N=4 -> 25 at cycle 9.
        s_i = 12'sd3; s_q = 12'sd4;
        run_window("t1", 2, 25, 9, 64'h55);
        finish_window("t1", 1'b0);
        $display("t1 full-rate window pwr=%0d", pwr_out_a);

        // Test 3: S_VALID every 3rd cycle -> same result, stalls are neutral.
        run_window("t3", 3, 25, 12, 64'h249);
        finish_window("t3", 1'b0);
        $display("t3 stalled window pwr=%0d", pwr_out_a);

        // Test 2: most negative samples, N=16, no sign flip.
        s_i = -12'sd2048; s_q = -12'sd2048;
        en_b = 1'b1; s_valid = 1'b0;
        step();
        c = 0; done = 0; prev_p = '0;
        while (!done && c < 100) begin
            s_valid = 1'b1;
            #1;
            if (pwr_valid_b) begin
                done = 1;
                chk("t2_cycle", c, 33);
                chk("t2_mac_p", prev_p, 64'd134217728);
                chk("t2_pwr", pwr_out_b, 64'd8388608);
            end else begin
                prev_p = mac_p_b;
                step();
                c++;
            end
        end
        chk("t2_done", done, 1);
        en_b = 1'b0; s_valid = 1'b0;
        step();
        $display("t2 extreme window pwr=%0d", pwr_out_b);

        // Test 4: abort after 2 of 4 samples, then a clean window.
        s_i = 12'sd3; s_q = 12'sd4;
        en_a = 1'b1; s_valid = 1'b0;
        step();
        s_valid = 1'b1; step();
        s_valid = 1'b0; step();
        s_valid = 1'b1; step();
        en_a = 1'b0; s_valid = 1'b0; step();
        #1;
        chk("t4_idle_ready", s_ready_a, 0);
        chk("t4_idle_sel", mac_sel_a, 0);
        for (int i = 0; i < 12; i++) begin
            chk("t4_no_valid", pwr_valid_a, 0);
            step();
        end
        chk("t4_pwr_kept", pwr_out_a, 25);
        s_i = 12'sd6; s_q = 12'sd8;
        run_window("t4", 2, 100, 9, 64'h55);
        finish_window("t4", 1'b0);
        $display("t4 post-abort window pwr=%0d", pwr_out_a);

        // Test 5: reset while in ST_Q.
        s_i = 12'sd3; s_q = 12'sd4;
        en_a = 1'b1; s_valid = 1'b0; step();
        s_valid = 1'b1; step();
        #1;
        chk("t5_stq_ready", s_ready_a, 0);
        chk("t5_stq_sel", mac_sel_a, 1);
        rst = 1'b1; en_a = 1'b0; s_valid = 1'b0;
        step();
        chk("t5_ready", s_ready_a, 0);
        chk("t5_sel", mac_sel_a, 0);
        chk("t5_valid", pwr_valid_a, 0);
        chk("t5_pwr", pwr_out_a, 0);
        chk("t5_ab", {mac_a_a, mac_b_a}, 0);
        rst = 1'b0;
        step();
        $display("t5 reset in ST_Q pwr=%0d", pwr_out_a);
`ifdef RSSI_PEAK_HOLD_EN
        chk("t6_peak_rst", peak_out_a, 0);
`endif

        // Test 6: windows 25, 100, 49, 49 with clear; peak tracking if enabled.
        s_i = 12'sd3; s_q = 12'sd4;
        run_window("t6a", 2, 25, 9, 64'h55);
        finish_window("t6a", 1'b0);
`ifdef RSSI_PEAK_HOLD_EN
        chk("t6a_peak", peak_out_a, 25);
`endif
        s_i = 12'sd6; s_q = 12'sd8;
        run_window("t6b", 2, 100, 9, 64'h55);
        finish_window("t6b", 1'b0);
`ifdef RSSI_PEAK_HOLD_EN
        chk("t6b_peak", peak_out_a, 100);
`endif
        s_i = 12'sd7; s_q = 12'sd0;
        run_window("t6c", 2, 49, 9, 64'h55);
        finish_window("t6c", 1'b0);
`ifdef RSSI_PEAK_HOLD_EN
        chk("t6c_peak", peak_out_a, 100);
`endif
        s_i = -12'sd7; s_q = 12'sd0;
        run_window("t6d", 2, 49, 9, 64'h55);
        finish_window("t6d", 1'b1);
`ifdef RSSI_PEAK_HOLD_EN
        chk("t6d_peak_clr_valid", peak_out_a, 49);
        peak_clr = 1'b1; step(); peak_clr = 1'b0;
        chk("t6e_peak_clr", peak_out_a, 0);
        chk("t6e_pwr_kept", pwr_out_a, 49);
`endif
        $display("t6 window sequence pwr=%0d", pwr_out_a);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
